signed_spm_seq: RTL and testbench

Sequential signed (two's-complement) serial-parallel multiplier core: parallel multiplicand, multiplier bits consumed serially LSB-first, one bit per clock.
Contains the bit-step controller and the internal mod-N bit counter that sequences the datapath.
Sits between the operand source (start/a/b) and the product consumer (p_valid/p_ready).
Produces one 2N-bit signed product per transaction.

---
 rtl/signed_spm_seq.sv | 93 +++++++++
 tb/tb_signed_spm_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_spm_seq.sv
// Sequential two's-complement serial-parallel multiplier. The multiplier is consumed LSB-first,
// one bit per clock. The product is held under a valid/ready handshake.
module signed_spm_seq #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic [2*N-1:0] p,
  output logic           p_valid,
  input  logic           p_ready
);

  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [N:0]    acc_q;
  logic [N-1:0]  mcand_q;
  logic [N-1:0]  mplier_q;
  logic [N-1:0]  low_q;

  logic          last;
  logic [N:0]    addend;
  logic [N:0]    sum;
  logic [N:0]    acc_nxt;
  logic [N-1:0]  low_nxt;

  // The last step handles the multiplier sign bit, whose weight is negative, so it subtracts.
  always_comb begin
    last    = (cnt_q == LastCnt);
    addend  = mplier_q[0] ? {mcand_q[N-1], mcand_q} : '0;
    sum     = last ? (acc_q - addend) : (acc_q + addend);
    acc_nxt = {sum[N], sum[N:1]};
    low_nxt = {sum[0], low_q[N-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      low_q    <= '0;
      busy     <= 1'b0;
      p        <= '0;
      p_valid  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            low_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_q    <= acc_nxt;
          low_q    <= low_nxt;
          mplier_q <= {1'b0, mplier_q[N-1:1]};
          if (last) begin
            cnt_q   <= '0;
            p       <= {acc_nxt[N-1:0], low_nxt};
            p_valid <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          if (p_ready) begin
            p_valid <= 1'b0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_spm_seq.sv
// Directed and randomized bench for signed_spm_seq at N=8.
module tb_signed_spm_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic [15:0] p;
  logic        p_valid;
  logic        p_ready;

  int n_checks = 0;
  int n_fail   = 0;

  signed_spm_seq #(.N(8), .CW(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .p       (p),
    .p_valid (p_valid),
    .p_ready (p_ready)
  );

  always #5 clk = ~clk;

  // Issues one start and waits (bounded) for p_valid; edges counts the accepting edge as 1.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        output logic [15:0] po, output int edges, output bit to);
    @(negedge clk);
    a     = ia;
    b     = ib;
    start = 1'b1;
    edges = 0;
    to    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      edges++;
      if (p_valid) begin
        to = 1'b0;
        break;
      end
    end
    po = p;
  endtask

  task automatic test_reset;
    reset   = 1'b0;
    start   = 1'b0;
    p_ready = 1'b0;
    a       = '0;
    b       = '0;
    #3;
    n_checks++;
    if ({busy, p_valid, p} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b p_valid=%b p=%h, required 0 0 0000", busy, p_valid, p);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] po;
    int edges;
    bit to;
    p_ready = 1'b1;
    run_op(8'd3, 8'd5, po, edges, to);
    n_checks++;
    if (to || edges !== 9) begin
      n_fail++;
      $display("FAIL basic_latency: edges=%0d timeout=%0d, required 9 0", edges, to);
    end
    n_checks++;
    if (po !== 16'h000F) begin
      n_fail++;
      $display("FAIL basic_p: p=%h, required 000f", po);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (p_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_handshake: p_valid=%b busy=%b, required 0 0", p_valid, busy);
    end
    n_checks++;
    if (p !== 16'h000F) begin
      n_fail++;
      $display("FAIL basic_p_retained: p=%h, required 000f", p);
    end
  endtask

  task automatic test_vectors;
    logic [7:0]  va [7] = '{8'hFD, 8'h05, 8'hFD, 8'h80, 8'h80, 8'h7F, 8'h00};
    logic [7:0]  vb [7] = '{8'h05, 8'hFD, 8'hFB, 8'h80, 8'h7F, 8'h7F, 8'h80};
    logic [15:0] vp [7] = '{16'hFFF1, 16'hFFF1, 16'h000F, 16'h4000, 16'hC080, 16'h3F01, 16'h0000};
    logic [15:0] po;
    int edges;
    bit to;
    p_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_op(va[i], vb[i], po, edges, to);
      n_checks++;
      if (to || po !== vp[i] || edges !== 9) begin
        n_fail++;
        $display("FAIL vector_%0d: a=%h b=%h p=%h edges=%0d timeout=%0d, required p=%h edges=9",
                 i, va[i], vb[i], po, edges, to, vp[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] po;
    int edges;
    bit to;
    p_ready = 1'b0;
    run_op(8'd7, 8'd9, po, edges, to);
    n_checks++;
    if (to || po !== 16'h003F) begin
      n_fail++;
      $display("FAIL bp_p: p=%h timeout=%0d, required 003f", po, to);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b1;
      a     = 8'h11;
      b     = 8'h22;
      @(posedge clk);
      #1;
      n_checks++;
      if (p_valid !== 1'b1 || busy !== 1'b1 || p !== 16'h003F) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: p_valid=%b busy=%b p=%h, required 1 1 003f",
                 i, p_valid, busy, p);
      end
    end
    @(negedge clk);
    start   = 1'b0;
    p_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (p_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_handshake: p_valid=%b busy=%b, required 0 0", p_valid, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || p !== 16'h003F) begin
      n_fail++;
      $display("FAIL bp_no_queued_start: busy=%b p=%h, required 0 003f", busy, p);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] po;
    int edges;
    bit to;
    bit seen;
    p_ready = 1'b1;
    @(negedge clk);
    a     = 8'h55;
    b     = 8'h33;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || p_valid !== 1'b0 || p !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_run_reset: busy=%b p_valid=%b p=%h, required 0 0 0000", busy, p_valid, p);
    end
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (p_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL mid_run_discard: p_valid seen=1, required 0");
    end
    run_op(8'd2, 8'hFF, po, edges, to);
    n_checks++;
    if (to || po !== 16'hFFFE || edges !== 9) begin
      n_fail++;
      $display("FAIL post_reset_op: p=%h edges=%0d timeout=%0d, required fffe 9 0", po, edges, to);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] po;
    logic signed [7:0]  sa;
    logic signed [7:0]  sb;
    logic signed [15:0] expv;
    int edges;
    bit to;
    int handshakes = 0;
    for (int n = 0; n < 20; n++) begin
      sa = 8'($urandom);
      sb = 8'($urandom);
      expv = sa * sb;
      p_ready = 1'b0;
      run_op(sa, sb, po, edges, to);
      n_checks++;
      if (to || po !== expv) begin
        n_fail++;
        $display("FAIL b2b_%0d: a=%h b=%h p=%h timeout=%0d, required %h", n, sa, sb, po, to, expv);
      end
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        p_ready = 1'($urandom);
        @(posedge clk);
        #1;
        if (p_ready) begin
          handshakes++;
          break;
        end
        if (p_valid !== 1'b1 || p !== expv) begin
          n_checks++;
          n_fail++;
          $display("FAIL b2b_hold_%0d: p_valid=%b p=%h, required 1 %h", n, p_valid, p, expv);
        end
      end
      n_checks++;
      if (p_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_release_%0d: p_valid=%b busy=%b, required 0 0", n, p_valid, busy);
      end
    end
    n_checks++;
    if (handshakes !== 20) begin
      n_fail++;
      $display("FAIL b2b_handshakes: count=%0d, required 20", handshakes);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
